// File: rtl/jump_redirect_controller.sv
// Execute-stage control-flow redirect/flush/fault controller.
// Define JUMP_REDIRECT_STATS_EN to build the jump/mispredict statistics counters.
module jump_redirect_controller #(
    parameter int unsigned FLUSH_DEPTH = 2
) (
    input  logic        clock_i,
    input  logic        resetn_i,
    input  logic        valid_i,
    input  logic        flag_jump_i,
    input  logic [31:0] addr_target_i,
    input  logic [3:0]  exception_i,
    input  logic        fetch_ready_i,
    input  logic        fault_clear_i,
    output logic        redirect_valid_o,
    output logic [31:0] redirect_addr_o,
    output logic        flush_o,
    output logic        stall_o,
    output logic        fault_o,
    output logic [2:0]  fault_cause_o,
    output logic [31:0] fault_addr_o,
    output logic [31:0] stat_jumps_o,
    output logic [31:0] stat_redirects_o
);

    typedef enum logic [1:0] {IDLE, REDIRECT, DRAIN, FAULT} state_e;

    state_e      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [31:0] raddr_q, raddr_d;
    logic [2:0]  cause_q, cause_d;
    logic [31:0] faddr_q, faddr_d;
    logic        sample;

    assign sample = valid_i && (state_q == IDLE);

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        raddr_d = raddr_q;
        cause_d = cause_q;
        faddr_d = faddr_q;
        case (state_q)
            IDLE: begin
                // Alignment/func3 faults outrank a next-address mismatch.
                if (sample && flag_jump_i) begin
                    if (exception_i[3] || exception_i[1] || exception_i[0]) begin
                        state_d = FAULT;
                        cause_d = {exception_i[3], exception_i[1], exception_i[0]};
                        faddr_d = addr_target_i;
                    end else if (exception_i[2]) begin
                        state_d = REDIRECT;
                        raddr_d = addr_target_i;
                    end
                end
            end
            REDIRECT: begin
                if (fetch_ready_i) begin
                    state_d = DRAIN;
                    cnt_d   = 4'(FLUSH_DEPTH - 1);
                end
            end
            DRAIN: begin
                if (cnt_q == 4'd0) state_d = IDLE;
                else               cnt_d   = cnt_q - 4'd1;
            end
            FAULT: begin
                if (fault_clear_i) begin
                    state_d = IDLE;
                    cause_d = 3'd0;
                    faddr_d = 32'd0;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clock_i or negedge resetn_i) begin
        if (!resetn_i) begin
            state_q <= IDLE;
            cnt_q   <= 4'd0;
            raddr_q <= 32'd0;
            cause_q <= 3'd0;
            faddr_q <= 32'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            raddr_q <= raddr_d;
            cause_q <= cause_d;
            faddr_q <= faddr_d;
        end
    end

    assign redirect_valid_o = (state_q == REDIRECT);
    assign redirect_addr_o  = raddr_q;
    assign flush_o          = (state_q != IDLE);
    assign stall_o          = (state_q != IDLE);
    assign fault_o          = (state_q == FAULT);
    assign fault_cause_o    = cause_q;
    assign fault_addr_o     = faddr_q;

`ifdef JUMP_REDIRECT_STATS_EN
    logic [31:0] stat_jumps_q, stat_redirects_q;

    always_ff @(posedge clock_i or negedge resetn_i) begin
        if (!resetn_i) begin
            stat_jumps_q     <= 32'd0;
            stat_redirects_q <= 32'd0;
        end else begin
            if (sample && flag_jump_i)
                stat_jumps_q <= stat_jumps_q + 32'd1;
            if (state_q == IDLE && state_d == REDIRECT)
                stat_redirects_q <= stat_redirects_q + 32'd1;
        end
    end

    assign stat_jumps_o     = stat_jumps_q;
    assign stat_redirects_o = stat_redirects_q;
`else
    assign stat_jumps_o     = 32'd0;
    assign stat_redirects_o = 32'd0;
`endif

endmodule

// File: tb/tb_jump_redirect_controller.sv
// Vector-table + scoreboard bench for jump_redirect_controller (FLUSH_DEPTH=2).
module tb_jump_redirect_controller;

    logic        clk = 1'b0;
    logic        rstn;
    logic        valid, jump, fready, fclear;
    logic [31:0] tgt;
    logic [3:0]  exc;
    logic        rv, flush, stall, fault;
    logic [31:0] raddr, faddr, sj, sr;
    logic [2:0]  cause;

    always #5 clk = ~clk;

    jump_redirect_controller #(.FLUSH_DEPTH(2)) dut (
        .clock_i(clk), .resetn_i(rstn), .valid_i(valid), .flag_jump_i(jump),
        .addr_target_i(tgt), .exception_i(exc), .fetch_ready_i(fready),
        .fault_clear_i(fclear), .redirect_valid_o(rv), .redirect_addr_o(raddr),
        .flush_o(flush), .stall_o(stall), .fault_o(fault), .fault_cause_o(cause),
        .fault_addr_o(faddr), .stat_jumps_o(sj), .stat_redirects_o(sr)
    );

    typedef struct packed {
        logic        rv, flush, stall, fault;
        logic [31:0] raddr;
        logic [2:0]  cause;
        logic [31:0] faddr, sj, sr;
    } outs_t;

    typedef struct {
        logic        v, j, fr, clr;
        logic [3:0]  exc;
        logic [31:0] tgt;
        logic        rv, fl, fa;   // fl covers flush and stall
        logic [31:0] raddr;
        logic [2:0]  cause;
        logic [31:0] faddr;
        logic        jinc, rinc;
    } vec_t;

    vec_t  vecs[22];
    outs_t exp_q[$];
    int    n_chk = 0, n_pass = 0;
    logic [31:0] mj = 0, mr = 0;

    function automatic outs_t actual();
        return '{rv, flush, stall, fault, raddr, cause, faddr, sj, sr};
    endfunction

    task automatic check(input string name, input outs_t exp);
        outs_t act = actual();
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    task automatic drive(input logic v, j, fr, clr, input logic [3:0] e, input logic [31:0] t);
        valid = v; jump = j; fready = fr; fclear = clr; exc = e; tgt = t;
    endtask

    function automatic outs_t mk(input logic r, fl, fa, input logic [31:0] ra,
                                 input logic [2:0] c, input logic [31:0] fad);
`ifdef JUMP_REDIRECT_STATS_EN
        return '{r, fl, fl, fa, ra, c, fad, mj, mr};
`else
        return '{r, fl, fl, fa, ra, c, fad, 32'd0, 32'd0};
`endif
    endfunction

    task automatic step_check(input string name);
        @(posedge clk); #1;
        check(name, exp_q.pop_front());
    endtask

    function automatic vec_t V(input logic v, j, fr, clr, input logic [3:0] e, input logic [31:0] t,
                               input logic r, fl, fa, input logic [31:0] ra, input logic [2:0] c,
                               input logic [31:0] fad, input logic ji, ri);
        return '{v, j, fr, clr, e, t, r, fl, fa, ra, c, fad, ji, ri};
    endfunction

    initial begin
        // v j fr clr exc tgt | rv fl fa raddr cause faddr | jinc rinc
        vecs[0]  = V(1,1,0,0,4'b0000,32'h2000, 0,0,0,32'h0000,3'b000,32'h000, 1,0); // correct prediction
        vecs[1]  = V(1,0,0,0,4'b1000,32'h2000, 0,0,0,32'h0000,3'b000,32'h000, 0,0); // exc ignored w/o jump
        vecs[2]  = V(0,1,0,0,4'b1000,32'h2000, 0,0,0,32'h0000,3'b000,32'h000, 0,0); // valid low
        vecs[3]  = V(1,1,0,0,4'b0100,32'h1000, 1,1,0,32'h1000,3'b000,32'h000, 1,1); // mispredict
        vecs[4]  = V(0,0,0,0,4'b0000,32'h0000, 1,1,0,32'h1000,3'b000,32'h000, 0,0);
        vecs[5]  = V(1,1,0,0,4'b1000,32'h0777, 1,1,0,32'h1000,3'b000,32'h000, 0,0); // ignored while stalled
        vecs[6]  = V(0,0,0,0,4'b0000,32'h0000, 1,1,0,32'h1000,3'b000,32'h000, 0,0);
        vecs[7]  = V(0,0,1,0,4'b0000,32'h0000, 0,1,0,32'h1000,3'b000,32'h000, 0,0); // accepted -> DRAIN
        vecs[8]  = V(1,1,0,0,4'b0100,32'h3000, 0,1,0,32'h1000,3'b000,32'h000, 0,0); // jump held in DRAIN
        vecs[9]  = V(1,1,0,0,4'b0100,32'h3000, 0,0,0,32'h1000,3'b000,32'h000, 0,0); // back to IDLE
        vecs[10] = V(1,1,0,0,4'b0100,32'h3000, 1,1,0,32'h3000,3'b000,32'h000, 1,1); // now sampled
        vecs[11] = V(0,0,1,0,4'b0000,32'h0000, 0,1,0,32'h3000,3'b000,32'h000, 0,0);
        vecs[12] = V(0,0,0,0,4'b0000,32'h0000, 0,1,0,32'h3000,3'b000,32'h000, 0,0);
        vecs[13] = V(0,0,0,0,4'b0000,32'h0000, 0,0,0,32'h3000,3'b000,32'h000, 0,0);
        vecs[14] = V(1,1,0,0,4'b0101,32'h0102, 0,1,1,32'h3000,3'b001,32'h102, 1,0); // fault beats mismatch
        vecs[15] = V(1,1,1,0,4'b0100,32'h0999, 0,1,1,32'h3000,3'b001,32'h102, 0,0); // held in FAULT
        vecs[16] = V(0,0,0,1,4'b0000,32'h0000, 0,0,0,32'h3000,3'b000,32'h000, 0,0); // clear
        vecs[17] = V(1,1,0,1,4'b0000,32'h0abc, 0,0,0,32'h3000,3'b000,32'h000, 1,0); // clear ignored in IDLE
        vecs[18] = V(1,1,0,0,4'b1000,32'h0abc, 0,1,1,32'h3000,3'b100,32'habc, 1,0); // bad func3
        vecs[19] = V(0,0,0,1,4'b0000,32'h0000, 0,0,0,32'h3000,3'b000,32'h000, 0,0);
        vecs[20] = V(1,1,0,0,4'b0110,32'h0055, 0,1,1,32'h3000,3'b010,32'h055, 1,0); // word misaligned
        vecs[21] = V(0,0,0,1,4'b0000,32'h0000, 0,0,0,32'h3000,3'b000,32'h000, 0,0);

        drive(0,0,0,0,4'b0,32'h0);
        rstn = 1'b0;
        #12;
        check("reset", '0);
        @(negedge clk); rstn = 1'b1;

        foreach (vecs[i]) begin
            drive(vecs[i].v, vecs[i].j, vecs[i].fr, vecs[i].clr, vecs[i].exc, vecs[i].tgt);
            mj += 32'(vecs[i].jinc); mr += 32'(vecs[i].rinc);
            exp_q.push_back(mk(vecs[i].rv, vecs[i].fl, vecs[i].fa, vecs[i].raddr,
                               vecs[i].cause, vecs[i].faddr));
            step_check($sformatf("vec%0d", i));
        end

        // Reset during the second DRAIN cycle abandons the redirect.
        drive(1,1,1,0,4'b0100,32'h5000); mj++; mr++;
        exp_q.push_back(mk(1,1,0,32'h5000,3'b000,32'h0)); step_check("rst_seq_redirect");
        drive(0,0,1,0,4'b0,32'h0);
        exp_q.push_back(mk(0,1,0,32'h5000,3'b000,32'h0)); step_check("rst_seq_drain1");
        exp_q.push_back(mk(0,1,0,32'h5000,3'b000,32'h0)); step_check("rst_seq_drain2");
        rstn = 1'b0; mj = 0; mr = 0;
        #1 check("rst_mid_drain", '0);
        @(negedge clk); #1 check("rst_held", '0);
        rstn = 1'b1;
        drive(1,1,0,0,4'b0100,32'h4000); mj++; mr++;
        exp_q.push_back(mk(1,1,0,32'h4000,3'b000,32'h0)); step_check("post_rst_sample");
        drive(0,0,0,0,4'b0,32'h0);
        exp_q.push_back(mk(1,1,0,32'h4000,3'b000,32'h0)); step_check("post_rst_no_replay");
        drive(0,0,1,0,4'b0,32'h0);
        exp_q.push_back(mk(0,1,0,32'h4000,3'b000,32'h0)); step_check("post_rst_drain");
        drive(0,0,0,0,4'b0,32'h0);
        exp_q.push_back(mk(0,1,0,32'h4000,3'b000,32'h0)); step_check("post_rst_drain2");
        exp_q.push_back(mk(0,0,0,32'h4000,3'b000,32'h0)); step_check("post_rst_idle");

`ifdef JUMP_REDIRECT_STATS_EN
        dut.stat_jumps_q = 32'hFFFF_FFFF; mj = 32'hFFFF_FFFF;
`endif
        drive(1,1,0,0,4'b0000,32'h0); mj++;
        exp_q.push_back(mk(0,0,0,32'h4000,3'b000,32'h0)); step_check("stat_wrap");
        drive(0,0,0,0,4'b0,32'h0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
